// File: rtl/char_vram_writer.sv
// Character stream to VRAM writer: cursor tracking, auto-wrap, circular-row scroll, screen/row clearing.
// Optional feature: define CHAR_WRITER_BACKSPACE_EN to make 0x08 a destructive backspace.
module char_vram_writer #(
  parameter int         COLS  = 70,
  parameter int         ROWS  = 30,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  input  logic        clear_req,
  output logic        vram_wen,
  output logic [11:0] vram_waddr,
  output logic [7:0]  vram_wdata,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic [4:0]  top_row,
  output logic        busy
);

  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
  localparam logic [5:0] ROWS_W   = 6'(ROWS);

  typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_ROW} state_t;

  state_t      state, state_d;
  logic [4:0]  clr_row, clr_row_d;
  logic [6:0]  clr_col, clr_col_d;
  logic [4:0]  clr_target, clr_target_d;
  logic        clr_pending, clr_pending_d;
  logic [4:0]  row_d, top_d;
  logic [6:0]  col_d;
  logic        wen_d;
  logic [11:0] waddr_d;
  logic [7:0]  wdata_d;
  logic        do_nl;
  logic        take;
  logic        is_print;
  logic [4:0]  phys_row;

  // Row arithmetic is modulo ROWS; operands are always < ROWS.
  function automatic logic [4:0] row_add(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= ROWS_W) s = s - ROWS_W;
    return s[4:0];
  endfunction

  function automatic logic [4:0] row_inc(input logic [4:0] a);
    return (a == ROW_LAST) ? 5'd0 : a + 5'd1;
  endfunction

`ifdef CHAR_WRITER_BACKSPACE_EN
  function automatic logic [4:0] row_dec(input logic [4:0] a);
    return (a == 5'd0) ? ROW_LAST : a - 5'd1;
  endfunction

  logic [4:0] phys_prev;
  assign phys_prev = row_dec(phys_row);
`endif

  assign phys_row = row_add(top_row, cursor_row);
  assign ch_ready = (state == IDLE) && !clear_req && !clr_pending;
  assign busy     = (state != IDLE);
  assign take     = ch_valid && ch_ready;
  assign is_print = (ch_data >= 8'h20) && (ch_data <= 8'h7E);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= CLR_ALL;
      clr_row     <= '0;
      clr_col     <= '0;
      clr_target  <= '0;
      clr_pending <= 1'b0;
      cursor_row  <= '0;
      cursor_col  <= '0;
      top_row     <= '0;
      vram_wen    <= 1'b0;
      vram_waddr  <= '0;
      vram_wdata  <= '0;
    end else begin
      state       <= state_d;
      clr_row     <= clr_row_d;
      clr_col     <= clr_col_d;
      clr_target  <= clr_target_d;
      clr_pending <= clr_pending_d;
      cursor_row  <= row_d;
      cursor_col  <= col_d;
      top_row     <= top_d;
      vram_wen    <= wen_d;
      vram_waddr  <= waddr_d;
      vram_wdata  <= wdata_d;
    end
  end

  always_comb begin
    state_d       = state;
    clr_row_d     = clr_row;
    clr_col_d     = clr_col;
    clr_target_d  = clr_target;
    clr_pending_d = clr_pending;
    row_d         = cursor_row;
    col_d         = cursor_col;
    top_d         = top_row;
    wen_d         = 1'b0;
    waddr_d       = vram_waddr;
    wdata_d       = vram_wdata;
    do_nl         = 1'b0;

    unique case (state)
      CLR_ALL: begin
        wen_d         = 1'b1;
        waddr_d       = {clr_row, clr_col};
        wdata_d       = BLANK;
        clr_pending_d = 1'b0;
        if (clr_col == COL_LAST) begin
          clr_col_d = '0;
          if (clr_row == ROW_LAST) begin
            state_d   = IDLE;
            clr_row_d = '0;
            row_d     = '0;
            col_d     = '0;
            top_d     = '0;
          end else begin
            clr_row_d = clr_row + 5'd1;
          end
        end else begin
          clr_col_d = clr_col + 7'd1;
        end
      end

      IDLE: begin
        if (clear_req) begin
          state_d   = CLR_ALL;
          clr_row_d = '0;
          clr_col_d = '0;
          row_d     = '0;
          col_d     = '0;
        end else if (take) begin
          if (is_print) begin
            wen_d   = 1'b1;
            waddr_d = {phys_row, cursor_col};
            wdata_d = ch_data;
            if (cursor_col == COL_LAST) do_nl = 1'b1;
            else                        col_d = cursor_col + 7'd1;
          end else if (ch_data == 8'h0A) begin
            do_nl = 1'b1;
          end else if (ch_data == 8'h0D) begin
            col_d = '0;
`ifdef CHAR_WRITER_BACKSPACE_EN
          end else if (ch_data == 8'h08) begin
            if (cursor_col != 7'd0) begin
              col_d   = cursor_col - 7'd1;
              wen_d   = 1'b1;
              waddr_d = {phys_row, cursor_col - 7'd1};
              wdata_d = BLANK;
            end else if (cursor_row != 5'd0) begin
              row_d   = cursor_row - 5'd1;
              col_d   = COL_LAST;
              wen_d   = 1'b1;
              waddr_d = {phys_prev, COL_LAST};
              wdata_d = BLANK;
            end
`endif
          end

          // Newline at the bottom scrolls: the old top row becomes the new bottom and is blanked.
          if (do_nl) begin
            col_d = '0;
            if (cursor_row != ROW_LAST) begin
              row_d = cursor_row + 5'd1;
            end else begin
              top_d        = row_inc(top_row);
              clr_target_d = top_row;
              clr_col_d    = '0;
              state_d      = CLR_ROW;
            end
          end
        end
      end

      CLR_ROW: begin
        wen_d   = 1'b1;
        waddr_d = {clr_target, clr_col};
        wdata_d = BLANK;
        if (clear_req) clr_pending_d = 1'b1;
        if (clr_col == COL_LAST) begin
          clr_col_d = '0;
          if (clr_pending || clear_req) begin
            state_d       = CLR_ALL;
            clr_row_d     = '0;
            clr_pending_d = 1'b0;
            row_d         = '0;
            col_d         = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clr_col_d = clr_col + 7'd1;
        end
      end

      default: state_d = CLR_ALL;
    endcase
  end

endmodule

// File: tb/tb_char_vram_writer.sv
// Randomized bench for char_vram_writer against a screen/cursor reference model.
// Honours CHAR_WRITER_BACKSPACE_EN the same way as the design.
module tb_char_vram_writer;

  localparam int COLS  = 70;
  localparam int ROWS  = 30;
  localparam int BLANK = 8'h20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ch_valid = 1'b0;
  logic [7:0]  ch_data = 8'h00;
  logic        clear_req = 1'b0;
  logic        ch_ready;
  logic        vram_wen;
  logic [11:0] vram_waddr;
  logic [7:0]  vram_wdata;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic [4:0]  top_row;
  logic        busy;

  always #5 clk = ~clk;

  char_vram_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(8'h20)) dut (
    .clk        (clk),
    .rst        (rst),
    .ch_valid   (ch_valid),
    .ch_data    (ch_data),
    .ch_ready   (ch_ready),
    .clear_req  (clear_req),
    .vram_wen   (vram_wen),
    .vram_waddr (vram_waddr),
    .vram_wdata (vram_wdata),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .top_row    (top_row),
    .busy       (busy)
  );

  int n_chk = 0;
  int n_bad = 0;
  int oob   = 0;
  int last_waits = 0;

  logic [7:0] shadow [4096];
  int         m_mem  [4096];
  int         m_row, m_col, m_top;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Every DUT write lands in a shadow VRAM for the final screen comparison.
  always @(negedge clk) begin
    if (rst && vram_wen) begin
      shadow[vram_waddr] = vram_wdata;
      if (int'(vram_waddr[6:0]) >= COLS || int'(vram_waddr[11:7]) >= ROWS) oob++;
    end
  end

  task automatic model_blank_all();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m_mem[r*128 + c] = BLANK;
    m_row = 0; m_col = 0; m_top = 0;
  endtask

  task automatic model_newline(output bit sc);
    sc = 0;
    m_col = 0;
    if (m_row < ROWS - 1) m_row++;
    else begin
      for (int c = 0; c < COLS; c++) m_mem[m_top*128 + c] = BLANK;
      m_top = (m_top + 1) % ROWS;
      sc = 1;
    end
  endtask

  task automatic model_step(input int c, output bit ew, output int ea, output int ed, output bit sc);
    int phys;
    ew = 0; ea = 0; ed = 0; sc = 0;
    phys = (m_top + m_row) % ROWS;
    if (c >= 32 && c <= 126) begin
      ew = 1; ea = phys*128 + m_col; ed = c; m_mem[ea] = c;
      m_col++;
      if (m_col == COLS) model_newline(sc);
    end else if (c == 10) begin
      model_newline(sc);
    end else if (c == 13) begin
      m_col = 0;
`ifdef CHAR_WRITER_BACKSPACE_EN
    end else if (c == 8) begin
      if (m_col > 0) begin
        m_col--;
        ew = 1; ea = phys*128 + m_col; ed = BLANK; m_mem[ea] = BLANK;
      end else if (m_row > 0) begin
        m_row--; m_col = COLS - 1;
        ew = 1; ea = ((m_top + m_row) % ROWS)*128 + m_col; ed = BLANK; m_mem[ea] = BLANK;
      end
`endif
    end
  endtask

  task automatic check_cursor(input string tag);
    check_eq({tag, "_row"}, int'(cursor_row), m_row);
    check_eq({tag, "_col"}, int'(cursor_col), m_col);
    check_eq({tag, "_top"}, int'(top_row), m_top);
  endtask

  // Offer one character; entry and exit are 1 time unit after a rising edge.
  task automatic send(input int c, input bit clr_mid);
    bit ew, sc;
    int ea, ed, waits, wr, badw, old_top;
    ch_valid = 1'b1;
    ch_data  = 8'(c);
    waits = 0;
    while (!ch_ready && waits < 5000) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!ch_ready) begin
      check_eq("ready_timeout", 0, 1);
      ch_valid = 1'b0;
      return;
    end
    last_waits = waits;
    model_step(c, ew, ea, ed, sc);
    @(posedge clk); #1;
    ch_valid = 1'b0;
    check_eq("char_wen", int'(vram_wen), int'(ew));
    if (ew) begin
      check_eq("char_addr", int'(vram_waddr), ea);
      check_eq("char_data", int'(vram_wdata), ed);
    end
    check_cursor("char");
    if (sc) begin
      old_top = (m_top + ROWS - 1) % ROWS;
      wr = 0; badw = 0;
      for (int i = 0; i < 5000; i++) begin
        @(posedge clk); #1;
        clear_req = clr_mid && (i == 5);
        if (vram_wen) begin
          if (wr < COLS && (int'(vram_waddr) != old_top*128 + wr || int'(vram_wdata) != BLANK)) badw++;
          wr++;
        end
        if (ch_ready) break;
      end
      clear_req = 1'b0;
      check_eq("scroll_writes", wr, clr_mid ? COLS + ROWS*COLS : COLS);
      check_eq("scroll_row_addr", badw, 0);
      check_eq("scroll_ready", int'(ch_ready), 1);
      if (clr_mid) model_blank_all();
      check_cursor("after_scroll");
    end
  endtask

  task automatic do_clear();
    int wr;
    ch_valid  = 1'b1;
    ch_data   = 8'h41;
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    ch_valid  = 1'b0;
    check_eq("clr_no_char", int'(vram_wen), 0);
    check_eq("clr_home_row", int'(cursor_row), 0);
    check_eq("clr_home_col", int'(cursor_col), 0);
    check_eq("clr_busy", int'(busy), 1);
    wr = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      if (vram_wen) wr++;
      if (ch_ready) break;
    end
    check_eq("clr_writes", wr, ROWS*COLS);
    model_blank_all();
    check_cursor("clr_done");
  endtask

  initial begin
    int cnt, badw, distinct, first, wsum, sel, a;
    bit seen [4096];

    // Reset values while held in reset.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_wen", int'(vram_wen), 0);
    check_eq("rst_waddr", int'(vram_waddr), 0);
    check_eq("rst_wdata", int'(vram_wdata), 0);
    check_eq("rst_row", int'(cursor_row), 0);
    check_eq("rst_col", int'(cursor_col), 0);
    check_eq("rst_top", int'(top_row), 0);
    check_eq("rst_ready", int'(ch_ready), 0);
    check_eq("rst_busy", int'(busy), 1);

    // Asynchronous reset in the middle of the power-on clear.
    rst = 1'b1;
    repeat (50) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_eq("async_rst_wen", int'(vram_wen), 0);
    check_eq("async_rst_waddr", int'(vram_waddr), 0);
    check_eq("async_rst_busy", int'(busy), 1);
    @(posedge clk); #1;
    rst = 1'b1;

    cnt = 0; badw = 0; distinct = 0; first = -1;
    foreach (seen[k]) seen[k] = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      if (vram_wen) begin
        a = int'(vram_waddr);
        if (first < 0) first = i;
        if (int'(vram_wdata) != BLANK || (a % 128) >= COLS || (a / 128) >= ROWS) badw++;
        if (!seen[a]) begin seen[a] = 1'b1; distinct++; end
        cnt++;
      end
      if (ch_ready) break;
    end
    check_eq("init_first_cycle", first, 0);
    check_eq("init_writes", cnt, ROWS*COLS);
    check_eq("init_distinct", distinct, ROWS*COLS);
    check_eq("init_bad_writes", badw, 0);
    check_eq("init_ready", int'(ch_ready), 1);
    check_eq("init_busy", int'(busy), 0);
    model_blank_all();
    check_cursor("init");
    @(posedge clk); #1;
    check_eq("idle_quiet", int'(vram_wen), 0);

    // Back-to-back printable characters.
    send(8'h41, 1'b0);
    send(8'h42, 1'b0);
    check_eq("b2b_waits", last_waits, 0);
    check_eq("b2b_addr", int'(vram_waddr), 'h001);
    check_eq("b2b_col", int'(cursor_col), 2);

    // Full line with auto-wrap, no stall.
    send(8'h0D, 1'b0);
    wsum = 0;
    for (int i = 0; i < COLS; i++) begin
      send(8'h61 + (i % 26), 1'b0);
      wsum += last_waits;
    end
    check_eq("wrap_stall", wsum, 0);
    send(8'h5A, 1'b0);
    check_eq("wrap_waits", last_waits, 0);
    check_eq("wrap_addr", int'(vram_waddr), 'h080);

    // Walk to the bottom row and scroll.
    for (int i = 0; i < ROWS - 2; i++) send(8'h0A, 1'b0);
    check_eq("bottom_row", int'(cursor_row), ROWS - 1);
    send(8'h0A, 1'b0);
    check_eq("scroll_top", int'(top_row), 1);
    send(8'h58, 1'b0);
    check_eq("scroll_next_addr", int'(vram_waddr), 'h000);

    // Clear requested while a row clear is running.
    send(8'h0A, 1'b1);
    check_eq("pend_top", int'(top_row), 0);

    // Backspace across a row boundary and at home.
    send(8'h0A, 1'b0);
    send(8'h08, 1'b0);
`ifdef CHAR_WRITER_BACKSPACE_EN
    check_eq("bs_wrap_addr", int'(vram_waddr), 'h045);
    check_eq("bs_wrap_data", int'(vram_wdata), BLANK);
    check_eq("bs_wrap_col", int'(cursor_col), COLS - 1);
    check_eq("bs_wrap_row", int'(cursor_row), 0);
`else
    check_eq("bs_nop_wen", int'(vram_wen), 0);
    check_eq("bs_nop_col", int'(cursor_col), 0);
    check_eq("bs_nop_row", int'(cursor_row), 1);
`endif
    send(8'h08, 1'b0);
    do_clear();
    send(8'h08, 1'b0);
    check_eq("bs_home_wen", int'(vram_wen), 0);

    // Randomized mix of printable, control and junk codes.
    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 15));
      if (sel <= 9 || sel == 15) send(int'($urandom_range(8'h20, 8'h7E)), 1'b0);
      else if (sel <= 11)        send(8'h0A, 1'b0);
      else if (sel == 12)        send(8'h0D, 1'b0);
      else if (sel == 13)        send(8'h08, 1'b0);
      else                       send(int'($urandom_range(8'h80, 8'hFF)), 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    // Final screen contents versus the model.
    repeat (2) @(posedge clk);
    #1;
    badw = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (shadow[r*128 + c] !== 8'(m_mem[r*128 + c])) badw++;
    check_eq("screen_mismatches", badw, 0);
    check_eq("out_of_range_writes", oob, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
